cr_huf_comp_sq_mc: RTL

//  Multi-channel Huffman symbol queue: N_CH independent FIFOs in one shared array, between symbol map (writer) and

---
 rtl/cr_huf_comp_sq_mc_pkg.sv | 26 ++
 rtl/cr_huf_comp_sq_ch_ctl.sv | 78 +++++++
 rtl/cr_huf_comp_sq_mc.sv | 117 +++++++++++
 3 files changed

// File: rtl/cr_huf_comp_sq_mc_pkg.sv
// Shared types and width helpers for the multi-channel Huffman symbol queue.
package cr_huf_compPKG;

  localparam int SQ_DATA_W = 64;
  localparam int SQ_SEQ_W  = 4;
  localparam int SQ_BV_W   = 3;
  localparam int SQ_FLAG_W = 4;

  // Field layout of one queue entry, MSB..LSB, for the default widths.
  typedef struct packed {
    logic                 eot;
    logic                 sot;
    logic [SQ_BV_W-1:0]   byte_vld;
    logic                 tlast;
    logic                 eob;
    logic [SQ_SEQ_W-1:0]  seq_id;
    logic [SQ_DATA_W-1:0] data;
  } s_sq_mc_entry;

  localparam int SQ_ENTRY_W = $bits(s_sq_mc_entry);

  function automatic int sq_entry_w(int bv_w, int seq_w, int data_w);
    return SQ_FLAG_W + bv_w + seq_w + data_w;
  endfunction

endpackage

// File: rtl/cr_huf_comp_sq_ch_ctl.sv
// Per-channel queue control: pointers, occupancy, frame count and status flags.
module cr_huf_comp_sq_ch_ctl #(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 1,
  parameter int STORE_FWD = 0,
  parameter int PTR_W     = 4,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_sel,
  input  logic             wr_eot,
  input  logic             rd_sel,
  input  logic             rd_eot,
  output logic             wr_acc,
  output logic             rd_acc,
  output logic             wr_rdy,
  output logic             empty,
  output logic             aempty,
  output logic             rd_avail,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] rptr,
  output logic [CNT_W-1:0] used
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] used_q, used_d, frame_q, frame_d;
  logic             full;

  assign full     = (used_q == DEPTH_C);
  assign empty    = (used_q == '0);
  assign aempty   = (used_q == ONE_C);
  assign rd_avail = (STORE_FWD != 0) ? (frame_q != '0) : !empty;
  assign wr_acc   = wr_sel & !full;
  assign rd_acc   = rd_sel & rd_avail;
  assign wr_rdy   = (used_q < AFULL_C) | (!full & !wr_sel);
  assign wptr     = wptr_q;
  assign rptr     = rptr_q;
  assign used     = used_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    used_d  = used_q;
    frame_d = frame_q;
    if (wr_acc) wptr_d = wptr_q + PTR_W'(1);
    if (rd_acc) rptr_d = rptr_q + PTR_W'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   used_d = used_q + ONE_C;
      2'b01:   used_d = used_q - ONE_C;
      default: used_d = used_q;
    endcase
    unique case ({wr_acc & wr_eot, rd_acc & rd_eot})
      2'b10:   frame_d = frame_q + ONE_C;
      2'b01:   frame_d = frame_q - ONE_C;
      default: frame_d = frame_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      used_q  <= '0;
      frame_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      used_q  <= used_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: rtl/cr_huf_comp_sq_mc.sv
// Multi-channel symbol queue: N_CH FIFOs sharing one flop array, with registered read port.
module cr_huf_comp_sq_mc
  import cr_huf_compPKG::*;
#(
  parameter int N_CH      = 4,
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 64,
  parameter int SEQ_W     = 4,
  parameter int AFULL_LVL = DEPTH - 1,
  parameter int STORE_FWD = 0,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int BV_W     = $clog2(DATA_W / 8),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic                  wr_eot,
  input  logic                  wr_sot,
  input  logic                  wr_tlast,
  input  logic                  wr_eob,
  input  logic [BV_W-1:0]       wr_byte_vld,
  input  logic [SEQ_W-1:0]      wr_seq_id,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [N_CH-1:0]       wr_rdy,
  input  logic                  rd,
  input  logic [CH_W-1:0]       rd_ch,
  output logic                  rd_vld,
  output logic                  rd_eot,
  output logic                  rd_sot,
  output logic                  rd_tlast,
  output logic                  rd_eob,
  output logic [BV_W-1:0]       rd_byte_vld,
  output logic [SEQ_W-1:0]      rd_seq_id,
  output logic [DATA_W-1:0]     rd_data,
  output logic [N_CH-1:0]       empty,
  output logic [N_CH-1:0]       aempty,
  output logic [N_CH-1:0]       rd_avail,
  output logic [N_CH*CNT_W-1:0] used_slots,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int E_W   = sq_entry_w(BV_W, SEQ_W, DATA_W);

  logic             wr_ch_ok, rd_ch_ok;
  logic [CH_W-1:0]  wr_ch_c, rd_ch_c;
  logic [N_CH-1:0]  wr_acc_v, rd_acc_v;
  logic             wr_acc_any, rd_acc_any;
  logic [PTR_W-1:0] wptr_v [N_CH];
  logic [PTR_W-1:0] rptr_v [N_CH];
  logic [E_W-1:0]   mem_q [N_CH*DEPTH];
  logic [E_W-1:0]   wr_entry, rd_entry, rd_ent_q;
  logic             rd_vld_q, overflow_q, underflow_q;

  assign wr_ch_ok   = 32'(wr_ch) < N_CH;
  assign rd_ch_ok   = 32'(rd_ch) < N_CH;
  assign wr_ch_c    = wr_ch_ok ? wr_ch : '0;
  assign rd_ch_c    = rd_ch_ok ? rd_ch : '0;
  assign wr_acc_any = |wr_acc_v;
  assign rd_acc_any = |rd_acc_v;
  assign wr_entry   = {wr_eot, wr_sot, wr_byte_vld, wr_tlast, wr_eob, wr_seq_id, wr_data};
  assign rd_entry   = mem_q[{rd_ch_c, rptr_v[rd_ch_c]}];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    cr_huf_comp_sq_ch_ctl #(
      .DEPTH     (DEPTH),
      .AFULL_LVL (AFULL_LVL),
      .STORE_FWD (STORE_FWD),
      .PTR_W     (PTR_W),
      .CNT_W     (CNT_W)
    ) u_ctl (
      .clk      (clk),
      .rst      (rst),
      .wr_sel   (wr & wr_ch_ok & (wr_ch == CH_W'(c))),
      .wr_eot   (wr_eot),
      .rd_sel   (rd & rd_ch_ok & (rd_ch == CH_W'(c))),
      .rd_eot   (rd_entry[E_W-1]),
      .wr_acc   (wr_acc_v[c]),
      .rd_acc   (rd_acc_v[c]),
      .wr_rdy   (wr_rdy[c]),
      .empty    (empty[c]),
      .aempty   (aempty[c]),
      .rd_avail (rd_avail[c]),
      .wptr     (wptr_v[c]),
      .rptr     (rptr_v[c]),
      .used     (used_slots[c*CNT_W +: CNT_W])
    );
  end

  // Storage holds no reset: occupancy counts alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc_any) mem_q[{wr_ch_c, wptr_v[wr_ch_c]}] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q    <= 1'b0;
      rd_ent_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc_any;
      if (rd_acc_any)         rd_ent_q    <= rd_entry;
      if (wr && !wr_acc_any)  overflow_q  <= 1'b1;
      if (rd && !rd_acc_any)  underflow_q <= 1'b1;
    end
  end

  assign rd_vld    = rd_vld_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign {rd_eot, rd_sot, rd_byte_vld, rd_tlast, rd_eob, rd_seq_id, rd_data} = rd_ent_q;

endmodule
